// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch FSM states and fetch constants.
package cpu_defs_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_CANCEL
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] FETCH_BYTES      = 32'd8;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues one memory request at a
// time and writes returned instruction pairs into the dual-write instruction FIFO.
module inst_fetch_ctrl
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter int          DISCARD_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    input  logic                     fifo_full,
    output logic                     inst_req,
    output logic [31:0]              inst_addr,
    input  logic                     inst_addr_ok,
    input  logic                     inst_data_ok,
    input  logic [31:0]              inst_rdata1,
    input  logic [31:0]              inst_rdata2,
    output logic                     fifo_rst,
    output logic                     write_en1,
    output logic                     write_en2,
    output logic [31:0]              write_address1,
    output logic [31:0]              write_address2,
    output logic [31:0]              write_data1,
    output logic [31:0]              write_data2,
    output logic [31:0]              fetch_pc_o,
    output logic [DISCARD_CNT_W-1:0] discard_cnt_o
);

    fetch_state_t             state, state_next;
    logic [31:0]              fetch_pc, fetch_pc_next;
    logic [31:0]              req_pc, req_pc_next;
    logic [DISCARD_CNT_W-1:0] discard_cnt;
    logic                     discard_inc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_REQ;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            discard_cnt <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_pc   <= req_pc_next;
            if (discard_inc && (discard_cnt != '1))
                discard_cnt <= discard_cnt + 1'b1;
        end
    end

    // A redirect always wins the fetch PC; a response that races a redirect is dropped.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_pc_next   = req_pc;
        discard_inc   = 1'b0;
        unique case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_pc;
                end else if (!fifo_full && inst_addr_ok) begin
                    req_pc_next = fetch_pc;
                    state_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_pc;
                    if (inst_data_ok) begin
                        discard_inc = 1'b1;
                        state_next  = S_REQ;
                    end else begin
                        state_next  = S_CANCEL;
                    end
                end else if (inst_data_ok) begin
                    fetch_pc_next = req_pc + (req_pc[2] ? 32'd4 : FETCH_BYTES);
                    state_next    = S_REQ;
                end
            end
            S_CANCEL: begin
                if (redirect_valid)
                    fetch_pc_next = redirect_pc;
                if (inst_data_ok) begin
                    discard_inc = 1'b1;
                    state_next  = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    // Outputs are gated by resetn so nothing leaks out while reset is held.
    always_comb begin
        inst_req       = resetn && (state == S_REQ) && !fifo_full && !redirect_valid;
        inst_addr      = fetch_pc;
        fifo_rst       = resetn && redirect_valid;
        write_en1      = resetn && (state == S_WAIT) && inst_data_ok && !redirect_valid;
        write_en2      = write_en1 && !req_pc[2];
        write_address1 = req_pc;
        write_address2 = req_pc + 32'd4;
        write_data1    = inst_rdata1;
        write_data2    = inst_rdata2;
        fetch_pc_o     = fetch_pc;
        discard_cnt_o  = discard_cnt;
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed, table-driven bench for inst_fetch_ctrl plus hand-written reset sequences.
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fifo_full;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata1;
    logic [31:0] inst_rdata2;
    logic        fifo_rst;
    logic        write_en1;
    logic        write_en2;
    logic [31:0] write_address1;
    logic [31:0] write_address2;
    logic [31:0] write_data1;
    logic [31:0] write_data2;
    logic [31:0] fetch_pc_o;
    logic [15:0] discard_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    inst_fetch_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fifo_full      (fifo_full),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata1    (inst_rdata1),
        .inst_rdata2    (inst_rdata2),
        .fifo_rst       (fifo_rst),
        .write_en1      (write_en1),
        .write_en2      (write_en2),
        .write_address1 (write_address1),
        .write_address2 (write_address2),
        .write_data1    (write_data1),
        .write_data2    (write_data2),
        .fetch_pc_o     (fetch_pc_o),
        .discard_cnt_o  (discard_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        ff;
        logic        aok;
        logic        dok;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_rst;
        logic        e_we1;
        logic        e_we2;
        logic [31:0] e_wa1;
        logic [31:0] e_wd1;
        logic [31:0] e_wd2;
        logic [15:0] e_disc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic rv, logic [31:0] rpc, logic ff, logic aok, logic dok,
        logic [31:0] rd1, logic [31:0] rd2,
        logic e_req, logic [31:0] e_addr, logic e_rst, logic e_we1, logic e_we2,
        logic [31:0] e_wa1, logic [31:0] e_wd1, logic [31:0] e_wd2, logic [15:0] e_disc);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.ff = ff; v.aok = aok; v.dok = dok;
        v.rd1 = rd1; v.rd2 = rd2;
        v.e_req = e_req; v.e_addr = e_addr; v.e_rst = e_rst;
        v.e_we1 = e_we1; v.e_we2 = e_we2; v.e_wa1 = e_wa1;
        v.e_wd1 = e_wd1; v.e_wd2 = e_wd2; v.e_disc = e_disc;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        fifo_full      = v.ff;
        inst_addr_ok   = v.aok;
        inst_data_ok   = v.dok;
        inst_rdata1    = v.rd1;
        inst_rdata2    = v.rd2;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        cmp({tag, " inst_req"},   32'(inst_req),      32'(v.e_req));
        cmp({tag, " inst_addr"},  inst_addr,          v.e_addr);
        cmp({tag, " fetch_pc_o"}, fetch_pc_o,         v.e_addr);
        cmp({tag, " fifo_rst"},   32'(fifo_rst),      32'(v.e_rst));
        cmp({tag, " write_en1"},  32'(write_en1),     32'(v.e_we1));
        cmp({tag, " write_en2"},  32'(write_en2),     32'(v.e_we2));
        cmp({tag, " discard"},    32'(discard_cnt_o), 32'(v.e_disc));
        if (v.e_we1) begin
            cmp({tag, " waddr1"}, write_address1, v.e_wa1);
            cmp({tag, " waddr2"}, write_address2, v.e_wa1 + 32'd4);
            cmp({tag, " wdata1"}, write_data1,    v.e_wd1);
            cmp({tag, " wdata2"}, write_data2,    v.e_wd2);
        end
    endtask

    initial begin
        //         rv rpc            ff aok dok rd1    rd2    req addr           rst we1 we2 wa1            wd1    wd2    disc
        vecs.push_back(mk(0, 32'h0,          0, 0, 0, 32'h0,  32'h0,  1, 32'hBFC0_0000, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd0));
        vecs.push_back(mk(0, 32'h0,          0, 1, 0, 32'h0,  32'h0,  1, 32'hBFC0_0000, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd0));
        vecs.push_back(mk(0, 32'h0,          0, 0, 0, 32'h0,  32'h0,  0, 32'hBFC0_0000, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd0));
        vecs.push_back(mk(0, 32'h0,          0, 0, 1, 32'h11, 32'h22, 0, 32'hBFC0_0000, 0, 1, 1, 32'hBFC0_0000, 32'h11, 32'h22, 16'd0));
        vecs.push_back(mk(1, 32'h8000_0004,  0, 0, 0, 32'h0,  32'h0,  0, 32'hBFC0_0008, 1, 0, 0, 32'h0,          32'h0,  32'h0,  16'd0));
        vecs.push_back(mk(0, 32'h0,          0, 1, 0, 32'h0,  32'h0,  1, 32'h8000_0004, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd0));
        vecs.push_back(mk(0, 32'h0,          0, 0, 1, 32'h33, 32'h44, 0, 32'h8000_0004, 0, 1, 0, 32'h8000_0004, 32'h33, 32'h44, 16'd0));
        vecs.push_back(mk(0, 32'h0,          0, 1, 0, 32'h0,  32'h0,  1, 32'h8000_0008, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd0));
        vecs.push_back(mk(1, 32'h8000_0100,  0, 0, 0, 32'h0,  32'h0,  0, 32'h8000_0008, 1, 0, 0, 32'h0,          32'h0,  32'h0,  16'd0));
        vecs.push_back(mk(0, 32'h0,          0, 0, 0, 32'h0,  32'h0,  0, 32'h8000_0100, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd0));
        vecs.push_back(mk(0, 32'h0,          0, 0, 1, 32'h55, 32'h66, 0, 32'h8000_0100, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd0));
        vecs.push_back(mk(0, 32'h0,          0, 0, 0, 32'h0,  32'h0,  1, 32'h8000_0100, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd1));
        vecs.push_back(mk(0, 32'h0,          0, 1, 0, 32'h0,  32'h0,  1, 32'h8000_0100, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd1));
        vecs.push_back(mk(1, 32'h8000_0200,  0, 0, 1, 32'h5A, 32'h5B, 0, 32'h8000_0100, 1, 0, 0, 32'h0,          32'h0,  32'h0,  16'd1));
        vecs.push_back(mk(0, 32'h0,          0, 0, 0, 32'h0,  32'h0,  1, 32'h8000_0200, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd2));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 32'h0,      1, 1, 0, 32'h0,  32'h0,  0, 32'h8000_0200, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd2));
        vecs.push_back(mk(0, 32'h0,          0, 1, 0, 32'h0,  32'h0,  1, 32'h8000_0200, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd2));
        vecs.push_back(mk(0, 32'h0,          0, 0, 1, 32'h77, 32'h88, 0, 32'h8000_0200, 0, 1, 1, 32'h8000_0200, 32'h77, 32'h88, 16'd2));
        vecs.push_back(mk(1, 32'hFFFF_FFF8,  0, 0, 0, 32'h0,  32'h0,  0, 32'h8000_0208, 1, 0, 0, 32'h0,          32'h0,  32'h0,  16'd2));
        vecs.push_back(mk(0, 32'h0,          0, 1, 0, 32'h0,  32'h0,  1, 32'hFFFF_FFF8, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd2));
        vecs.push_back(mk(0, 32'h0,          0, 0, 1, 32'h99, 32'hAA, 0, 32'hFFFF_FFF8, 0, 1, 1, 32'hFFFF_FFF8, 32'h99, 32'hAA, 16'd2));
        vecs.push_back(mk(0, 32'h0,          0, 0, 0, 32'h0,  32'h0,  1, 32'h0000_0000, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd2));
        vecs.push_back(mk(0, 32'h0,          0, 1, 0, 32'h0,  32'h0,  1, 32'h0000_0000, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd2));
        vecs.push_back(mk(1, 32'h0000_0100,  0, 0, 0, 32'h0,  32'h0,  0, 32'h0000_0000, 1, 0, 0, 32'h0,          32'h0,  32'h0,  16'd2));
        vecs.push_back(mk(1, 32'h0000_0200,  0, 0, 1, 32'hBB, 32'hCC, 0, 32'h0000_0100, 1, 0, 0, 32'h0,          32'h0,  32'h0,  16'd2));
        vecs.push_back(mk(0, 32'h0,          0, 0, 0, 32'h0,  32'h0,  1, 32'h0000_0200, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd3));
        vecs.push_back(mk(0, 32'h0,          0, 0, 1, 32'hDD, 32'hEE, 1, 32'h0000_0200, 0, 0, 0, 32'h0,          32'h0,  32'h0,  16'd3));

        resetn         = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1234_5678;
        fifo_full      = 1'b0;
        inst_addr_ok   = 1'b1;
        inst_data_ok   = 1'b1;
        inst_rdata1    = '0;
        inst_rdata2    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("reset inst_req",   32'(inst_req),      32'd0);
        cmp("reset fifo_rst",   32'(fifo_rst),      32'd0);
        cmp("reset write_en1",  32'(write_en1),     32'd0);
        cmp("reset write_en2",  32'(write_en2),     32'd0);
        cmp("reset fetch_pc_o", fetch_pc_o,         32'hBFC0_0000);
        cmp("reset discard",    32'(discard_cnt_o), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(vecs[0]);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i], $sformatf("v%0d", i));
            @(posedge clk);
            #1;
        end

        // Reset asserted while a response is pending: everything clears at once.
        applyStimulus(mk(0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 16'd0));
        @(posedge clk);
        #1;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata1  = 32'hDEAD_0001;
        inst_rdata2  = 32'hDEAD_0002;
        cmp("pre-reset inst_req", 32'(inst_req), 32'd0);
        resetn = 1'b0;
        #1;
        cmp("midreset inst_req",   32'(inst_req),      32'd0);
        cmp("midreset write_en1",  32'(write_en1),     32'd0);
        cmp("midreset write_en2",  32'(write_en2),     32'd0);
        cmp("midreset fetch_pc_o", fetch_pc_o,         32'hBFC0_0000);
        cmp("midreset discard",    32'(discard_cnt_o), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        cmp("stale write_en1", 32'(write_en1), 32'd0);
        cmp("stale write_en2", 32'(write_en2), 32'd0);
        cmp("stale inst_req",  32'(inst_req),  32'd1);
        cmp("stale inst_addr", inst_addr,      32'hBFC0_0000);
        @(posedge clk);
        #1;
        inst_data_ok = 1'b0;
        @(negedge clk);
        cmp("post inst_addr", inst_addr, 32'hBFC0_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
